bp_btb: RTL and testbench
=========================

Name: bp_btb

Overview:
- Parametrised successor to the single-configuration branch predictor: a direct-mapped branch target buffer with per-entry saturating counters and optional gshare indexing.
- Looks up the ID-stage PC combinationally and returns a taken/target prediction.
- Trains from resolved conditional branches in WB.
- Keeps saturating update and mispredict statistics for performance bring-up.

Parameters:
- WIDTH, 16, address/PC width in bits (bit 0 of every PC is always 0).
- ENTRIES, 16, number of BTB entries (power of 2, 2..256); IDX = log2(ENTRIES).
- CTR_BITS, 2, saturating counter width (1..4).
- GHR_BITS, 0, global history length; 0 = plain PC indexing, >0 = gshare (must be <= IDX).
- STAT_BITS, 16, width of statistics counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- lookup_pc  in  WIDTH  PC of instruction in ID
- predict_hit  out  1  valid entry with matching tag
- predict_taken  out  1  hit AND counter MSB = 1
- predict_target  out  WIDTH  stored target when hit, else 0
- predict_ghr  out  max(GHR_BITS,1)  GHR value used for this lookup (carried down the pipe)
- update_valid  in  1  one-cycle strobe: a conditional BR resolved in WB
- update_pc  in  WIDTH  PC of the resolved branch
- update_ghr  in  max(GHR_BITS,1)  predict_ghr captured at lookup
- update_taken  in  1  actual outcome
- update_target  in  WIDTH  actual taken target
- update_pred_taken  in  1  prediction carried with the branch
- stat_updates  out  STAT_BITS  count of update_valid strobes
- stat_mispredicts  out  STAT_BITS  count of updates where update_pred_taken != update_taken

Behaviour:
- Indexing:
  - idx = pc[IDX:1] XOR {zero-extend GHR} when GHR_BITS>0, else pc[IDX:1].
  - tag = pc[WIDTH-1:IDX+1].
  - Lookup uses the current GHR; update uses update_ghr, so both address the same entry.
- Lookup:
  - Purely combinational from registered state; zero latency.
  - No write-through bypass: a lookup in the same cycle as an update to that entry sees the pre-update value.
- Update, applied at the clk edge when update_valid=1:
  - Hit, taken: counter += 1, saturating at 2^CTR_BITS-1; target <= update_target.
  - Hit, not taken: counter -= 1, saturating at 0; target unchanged.
  - Miss, taken: allocate (overwrite any entry at idx). valid=1, tag written, target written, counter = 2^(CTR_BITS-1) (weakly taken).
  - Miss, not taken: no allocation, no change to the entry.
- GHR (GHR_BITS>0):
  - On update_valid, GHR <= {GHR[GHR_BITS-2:0], update_taken}; non-speculative.
  - With GHR_BITS=0, predict_ghr is driven 0 and update_ghr is ignored.
- Statistics:
  - stat_updates += 1 per update_valid.
  - stat_mispredicts += 1 when update_valid AND mismatch.
  - Both saturate at all-ones and never wrap.
- Reset (synchronous, active-high):
  - All valid bits = 0; counters = 2^(CTR_BITS-1)-1 (weakly not taken); targets and tags = 0; GHR = 0; stats = 0.
  - Outputs after reset: predict_hit=0, predict_taken=0, predict_target=0, predict_ghr=0.
  - Reset wins over a simultaneous update_valid.
  - Reset mid-training discards all state.
- Boundaries:
  - update_valid held high for N cycles = N independent updates.
  - Aliasing PCs with different tags evict each other only on a taken update.
  - CTR_BITS=1 degenerates to last-outcome prediction.

Test Plan:
- Reset, then lookup_pc=0x0040 -> predict_hit=0, predict_taken=0, predict_target=0x0000, stats=0.
- Defaults. Update pc=0x0040 taken, target=0x0010 -> next cycle lookup 0x0040: hit=1, taken=1 (ctr=2), target=0x0010. Two further not-taken updates -> ctr=0, taken=0, hit=1.
- Saturation. Five taken updates to 0x0040 -> ctr=3; one not-taken update -> ctr=2, still taken. Not-taken update on miss pc 0x0100 -> hit stays 0.
- Aliasing (ENTRIES=16). Install 0x0040 (idx 0) taken; taken update pc=0x0060 (idx 0, new tag), target 0x0200 -> lookup 0x0040 hit=0; lookup 0x0060 hit=1, target 0x0200.
- Same-cycle and stats. Update to 0x0040 and lookup of 0x0040 in the same cycle -> old value shown, new value the following cycle. 3 updates with pred/actual (1/0, 0/0, 0/1) -> stat_updates=3, stat_mispredicts=2.
- GHR_BITS=2. Updates taken, taken -> GHR=2'b11; lookup 0x0046 (pc[4:1]=3) indexes entry 0 and predict_ghr=2'b11. Update with update_ghr=2'b11 trains entry 0.

Source files
------------

// File: rtl/bp_btb.sv
`default_nettype none
// ============================================================================
//  Module   : bp_btb
//  Purpose  : Direct-mapped branch target buffer with saturating counters,
//             optional gshare indexing and update/mispredict statistics.
//  Revision : 1.0
// ============================================================================
module bp_btb #(
  parameter int WIDTH     = 16,
  parameter int ENTRIES   = 16,
  parameter int CTR_BITS  = 2,
  parameter int GHR_BITS  = 0,
  parameter int STAT_BITS = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [WIDTH-1:0]                     lookup_pc,
  output logic                                 predict_hit,
  output logic                                 predict_taken,
  output logic [WIDTH-1:0]                     predict_target,
  output logic [((GHR_BITS>0)?GHR_BITS:1)-1:0] predict_ghr,
  input  logic                                 update_valid,
  input  logic [WIDTH-1:0]                     update_pc,
  input  logic [((GHR_BITS>0)?GHR_BITS:1)-1:0] update_ghr,
  input  logic                                 update_taken,
  input  logic [WIDTH-1:0]                     update_target,
  input  logic                                 update_pred_taken,
  output logic [STAT_BITS-1:0]                 stat_updates,
  output logic [STAT_BITS-1:0]                 stat_mispredicts
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int GW   = (GHR_BITS > 0) ? GHR_BITS : 1;
  localparam int TAGW = WIDTH - IDX - 1;
  localparam logic [CTR_BITS-1:0]  CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0]  CTR_WT   = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0]  CTR_WNT  = CTR_WT - CTR_BITS'(1);
  localparam logic [STAT_BITS-1:0] STAT_MAX = '1;

  logic                 valid_q [ENTRIES];
  logic [TAGW-1:0]      tag_q   [ENTRIES];
  logic [WIDTH-1:0]     tgt_q   [ENTRIES];
  logic [CTR_BITS-1:0]  ctr_q   [ENTRIES];

  logic [GW-1:0]        ghr_q, ghr_d;
  logic [STAT_BITS-1:0] upd_cnt_q, upd_cnt_d;
  logic [STAT_BITS-1:0] mis_cnt_q, mis_cnt_d;

  logic [GW-1:0]        w_lk_hist, w_up_hist;
  logic [IDX-1:0]       w_lk_idx, w_up_idx;
  logic [TAGW-1:0]      w_lk_tag, w_up_tag;
  logic                 w_up_hit;
  logic                 w_unused;

  // Bit 0 of a PC is always zero; history input is meaningless in PC-only mode.
  assign w_unused = ^{lookup_pc[0], update_pc[0], update_ghr};

  generate
    if (GHR_BITS > 0) begin : g_gshare
      assign w_lk_hist = ghr_q;
      assign w_up_hist = update_ghr;
    end else begin : g_pcidx
      assign w_lk_hist = '0;
      assign w_up_hist = '0;
    end

    if (GHR_BITS > 1) begin : g_ghr_multi
      assign ghr_d = update_valid ? {ghr_q[GW-2:0], update_taken} : ghr_q;
    end else if (GHR_BITS == 1) begin : g_ghr_one
      assign ghr_d = update_valid ? update_taken : ghr_q;
    end else begin : g_ghr_none
      assign ghr_d = '0;
    end
  endgenerate

  // History is zero-extended to the index width before the XOR.
  always_comb begin
    w_lk_idx = '0;
    w_up_idx = '0;
    w_lk_idx[GW-1:0] = w_lk_hist;
    w_up_idx[GW-1:0] = w_up_hist;
    w_lk_idx = w_lk_idx ^ lookup_pc[IDX:1];
    w_up_idx = w_up_idx ^ update_pc[IDX:1];
    w_lk_tag = lookup_pc[WIDTH-1:IDX+1];
    w_up_tag = update_pc[WIDTH-1:IDX+1];
  end

  always_comb begin
    predict_hit    = valid_q[w_lk_idx] && (tag_q[w_lk_idx] == w_lk_tag);
    predict_taken  = predict_hit && ctr_q[w_lk_idx][CTR_BITS-1];
    predict_target = predict_hit ? tgt_q[w_lk_idx] : '0;
    predict_ghr    = ghr_q;
    w_up_hit       = valid_q[w_up_idx] && (tag_q[w_up_idx] == w_up_tag);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else if (update_valid) begin
      if (w_up_hit) begin
        if (update_taken) begin
          if (ctr_q[w_up_idx] != CTR_MAX) ctr_q[w_up_idx] <= ctr_q[w_up_idx] + CTR_BITS'(1);
          tgt_q[w_up_idx] <= update_target;
        end else if (ctr_q[w_up_idx] != '0) begin
          ctr_q[w_up_idx] <= ctr_q[w_up_idx] - CTR_BITS'(1);
        end
      end else if (update_taken) begin
        // Taken miss evicts whatever lives at this index.
        valid_q[w_up_idx] <= 1'b1;
        tag_q[w_up_idx]   <= w_up_tag;
        tgt_q[w_up_idx]   <= update_target;
        ctr_q[w_up_idx]   <= CTR_WT;
      end
    end
  end

  always_comb begin
    upd_cnt_d = upd_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (update_valid && (upd_cnt_q != STAT_MAX)) upd_cnt_d = upd_cnt_q + STAT_BITS'(1);
    if (update_valid && (update_pred_taken != update_taken) && (mis_cnt_q != STAT_MAX))
      mis_cnt_d = mis_cnt_q + STAT_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q     <= '0;
      upd_cnt_q <= '0;
      mis_cnt_q <= '0;
    end else begin
      ghr_q     <= ghr_d;
      upd_cnt_q <= upd_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign stat_updates     = upd_cnt_q;
  assign stat_mispredicts = mis_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bp_btb.sv
`default_nettype none
// Directed bench for bp_btb: default instance plus a gshare/1-bit-counter/2-bit-stat instance.
module tb_bp_btb;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] lookup_pc;
  logic        update_valid;
  logic [15:0] update_pc;
  logic [1:0]  update_ghr;
  logic        update_taken;
  logic [15:0] update_target;
  logic        update_pred_taken;

  logic        a_hit, a_taken;
  logic [15:0] a_target;
  logic [0:0]  a_ghr;
  logic [15:0] a_stu, a_stm;

  logic        b_hit, b_taken;
  logic [15:0] b_target;
  logic [1:0]  b_ghr;
  logic [1:0]  b_stu, b_stm;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bp_btb dut_a (
    .clk(clk), .reset(reset), .lookup_pc(lookup_pc),
    .predict_hit(a_hit), .predict_taken(a_taken), .predict_target(a_target),
    .predict_ghr(a_ghr), .update_valid(update_valid), .update_pc(update_pc),
    .update_ghr(update_ghr[0:0]), .update_taken(update_taken),
    .update_target(update_target), .update_pred_taken(update_pred_taken),
    .stat_updates(a_stu), .stat_mispredicts(a_stm)
  );

  bp_btb #(.WIDTH(16), .ENTRIES(16), .CTR_BITS(1), .GHR_BITS(2), .STAT_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .lookup_pc(lookup_pc),
    .predict_hit(b_hit), .predict_taken(b_taken), .predict_target(b_target),
    .predict_ghr(b_ghr), .update_valid(update_valid), .update_pc(update_pc),
    .update_ghr(update_ghr), .update_taken(update_taken),
    .update_target(update_target), .update_pred_taken(update_pred_taken),
    .stat_updates(b_stu), .stat_mispredicts(b_stm)
  );

  task automatic upd(input logic [15:0] pc, input logic tk, input logic [15:0] tgt,
                     input logic pred, input logic [1:0] g);
    update_valid = 1'b1; update_pc = pc; update_taken = tk;
    update_target = tgt; update_pred_taken = pred; update_ghr = g;
    @(posedge clk); #1;
    update_valid = 1'b0;
  endtask

  task automatic look(input logic [15:0] pc);
    lookup_pc = pc; #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    // An update coincident with reset must be discarded.
    reset = 1'b1;
    update_valid = 1'b1; update_pc = 16'h0040; update_taken = 1'b1;
    update_target = 16'h0010; update_pred_taken = 1'b0; update_ghr = 2'b11;
    @(posedge clk); #1;
    update_valid = 1'b0; reset = 1'b0;
    look(16'h0040);
    n_tests++; if (a_hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %0d want 0", a_hit); end
    n_tests++; if (a_taken !== 1'b0) begin n_fail++; $display("FAIL reset_taken: got %0d want 0", a_taken); end
    n_tests++; if (a_target !== 16'h0000) begin n_fail++; $display("FAIL reset_target: got %h want 0000", a_target); end
    n_tests++; if (a_stu !== 16'd0 || a_stm !== 16'd0) begin n_fail++; $display("FAIL reset_stats: got %0d/%0d want 0/0", a_stu, a_stm); end
    n_tests++; if (b_ghr !== 2'b00 || b_hit !== 1'b0) begin n_fail++; $display("FAIL reset_b: got ghr %b hit %0d want 00 0", b_ghr, b_hit); end
  endtask

  task automatic test_defaults();
    upd(16'h0040, 1'b1, 16'h0010, 1'b0, 2'b00);
    look(16'h0040);
    n_tests++; if ({a_hit, a_taken, a_target} !== {2'b11, 16'h0010}) begin n_fail++; $display("FAIL alloc: got hit %0d tk %0d tgt %h want 1 1 0010", a_hit, a_taken, a_target); end
    upd(16'h0040, 1'b0, 16'h0bad, 1'b1, 2'b00);
    look(16'h0040);
    n_tests++; if ({a_hit, a_taken} !== 2'b10) begin n_fail++; $display("FAIL nt1: got hit %0d tk %0d want 1 0", a_hit, a_taken); end
    upd(16'h0040, 1'b0, 16'h0bad, 1'b0, 2'b00);
    look(16'h0040);
    n_tests++; if ({a_hit, a_taken, a_target} !== {2'b10, 16'h0010}) begin n_fail++; $display("FAIL nt2: got hit %0d tk %0d tgt %h want 1 0 0010", a_hit, a_taken, a_target); end
  endtask

  task automatic test_saturation();
    // From ctr=0: five taken -> 3 (saturated); one NT -> 2 (taken); second NT -> 1 (not taken).
    for (int i = 0; i < 5; i++) upd(16'h0040, 1'b1, 16'h0020 + 16'(i), 1'b0, 2'b00);
    upd(16'h0040, 1'b0, 16'h0000, 1'b1, 2'b00);
    look(16'h0040);
    n_tests++; if ({a_hit, a_taken, a_target} !== {2'b11, 16'h0024}) begin n_fail++; $display("FAIL sat_hi: got hit %0d tk %0d tgt %h want 1 1 0024", a_hit, a_taken, a_target); end
    upd(16'h0040, 1'b0, 16'h0000, 1'b1, 2'b00);
    look(16'h0040);
    n_tests++; if ({a_hit, a_taken} !== 2'b10) begin n_fail++; $display("FAIL sat_dec: got hit %0d tk %0d want 1 0", a_hit, a_taken); end
    upd(16'h0100, 1'b0, 16'h0300, 1'b0, 2'b00);
    look(16'h0100);
    n_tests++; if (a_hit !== 1'b0) begin n_fail++; $display("FAIL miss_nt: got hit %0d want 0", a_hit); end
    look(16'h0040);
    n_tests++; if (a_hit !== 1'b1) begin n_fail++; $display("FAIL miss_nt_keep: got hit %0d want 1", a_hit); end
  endtask

  task automatic test_aliasing();
    upd(16'h0060, 1'b1, 16'h0200, 1'b0, 2'b00);
    look(16'h0040);
    n_tests++; if (a_hit !== 1'b0) begin n_fail++; $display("FAIL alias_evict: got hit %0d want 0", a_hit); end
    look(16'h0060);
    n_tests++; if ({a_hit, a_taken, a_target} !== {2'b11, 16'h0200}) begin n_fail++; $display("FAIL alias_new: got hit %0d tk %0d tgt %h want 1 1 0200", a_hit, a_taken, a_target); end
  endtask

  task automatic test_same_cycle();
    lookup_pc = 16'h0060;
    update_valid = 1'b1; update_pc = 16'h0060; update_taken = 1'b1;
    update_target = 16'h0300; update_pred_taken = 1'b1; update_ghr = 2'b00;
    #1;
    n_tests++; if (a_target !== 16'h0200) begin n_fail++; $display("FAIL same_old: got %h want 0200", a_target); end
    @(posedge clk); #1;
    update_valid = 1'b0; #1;
    n_tests++; if (a_target !== 16'h0300) begin n_fail++; $display("FAIL same_new: got %h want 0300", a_target); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    look(16'h0060);
    n_tests++; if (a_hit !== 1'b0) begin n_fail++; $display("FAIL midreset_hit: got %0d want 0", a_hit); end
    // update_valid held for three cycles counts three updates.
    update_valid = 1'b1; update_pc = 16'h0080; update_taken = 1'b1;
    update_target = 16'h0440; update_pred_taken = 1'b1; update_ghr = 2'b00;
    repeat (3) @(posedge clk);
    #1; update_valid = 1'b0;
    look(16'h0080);
    n_tests++; if (a_stu !== 16'd3 || a_stm !== 16'd0) begin n_fail++; $display("FAIL b2b_stats: got %0d/%0d want 3/0", a_stu, a_stm); end
    n_tests++; if ({a_hit, a_taken, a_target} !== {2'b11, 16'h0440}) begin n_fail++; $display("FAIL b2b_entry: got hit %0d tk %0d tgt %h want 1 1 0440", a_hit, a_taken, a_target); end
  endtask

  task automatic test_stats();
    upd(16'h0100, 1'b0, 16'h0000, 1'b1, 2'b00);
    upd(16'h0100, 1'b0, 16'h0000, 1'b0, 2'b00);
    upd(16'h0100, 1'b1, 16'h0500, 1'b0, 2'b00);
    n_tests++; if (a_stu !== 16'd6 || a_stm !== 16'd2) begin n_fail++; $display("FAIL stats: got %0d/%0d want 6/2", a_stu, a_stm); end
    n_tests++; if (b_stu !== 2'd3 || b_stm !== 2'd2) begin n_fail++; $display("FAIL stats_sat_u: got %0d/%0d want 3/2", b_stu, b_stm); end
    upd(16'h0100, 1'b0, 16'h0000, 1'b1, 2'b00);
    upd(16'h0100, 1'b0, 16'h0000, 1'b1, 2'b00);
    n_tests++; if (a_stu !== 16'd8 || a_stm !== 16'd4) begin n_fail++; $display("FAIL stats2: got %0d/%0d want 8/4", a_stu, a_stm); end
    n_tests++; if (b_stu !== 2'd3 || b_stm !== 2'd3) begin n_fail++; $display("FAIL stats_sat_m: got %0d/%0d want 3/3", b_stu, b_stm); end
  endtask

  task automatic test_gshare();
    do_reset();
    upd(16'h0002, 1'b1, 16'h0050, 1'b0, 2'b00);
    upd(16'h0002, 1'b1, 16'h0050, 1'b0, 2'b00);
    look(16'h0046);
    n_tests++; if (b_ghr !== 2'b11) begin n_fail++; $display("FAIL ghr_shift: got %b want 11", b_ghr); end
    n_tests++; if (b_hit !== 1'b0) begin n_fail++; $display("FAIL gs_pre: got hit %0d want 0", b_hit); end
    look(16'h0002);
    n_tests++; if (b_hit !== 1'b0) begin n_fail++; $display("FAIL gs_xor: got hit %0d want 0", b_hit); end
    upd(16'h0046, 1'b1, 16'h0070, 1'b0, 2'b11);
    look(16'h0046);
    n_tests++; if ({b_hit, b_taken, b_target} !== {2'b11, 16'h0070}) begin n_fail++; $display("FAIL gs_train: got hit %0d tk %0d tgt %h want 1 1 0070", b_hit, b_taken, b_target); end
    // 1-bit counter: one NT flips prediction; GHR becomes 10 so 0x0044 maps to entry 0.
    upd(16'h0046, 1'b0, 16'h0000, 1'b1, 2'b11);
    look(16'h0044);
    n_tests++; if ({b_ghr, b_hit, b_taken, b_target} !== {2'b10, 2'b10, 16'h0070}) begin n_fail++; $display("FAIL gs_last: got ghr %b hit %0d tk %0d tgt %h want 10 1 0 0070", b_ghr, b_hit, b_taken, b_target); end
  endtask

  initial begin
    reset = 1'b1; lookup_pc = '0; update_valid = 1'b0; update_pc = '0;
    update_ghr = '0; update_taken = 1'b0; update_target = '0; update_pred_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_defaults();
    test_saturation();
    test_aliasing();
    test_same_cycle();
    test_back_to_back();
    test_stats();
    test_gshare();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
